// File: rtl/rvga_cachebus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : rvga_cachebus_arbiter_pkg
// Brief  : Shared types and grant encodings for the cachebus arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package rvga_cachebus_arbiter_pkg;

    typedef logic [31:0] rvga_word;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_OWN_M0 = 2'd1,
        ARB_OWN_M1 = 2'd2
    } rvga_arb_state_e;

    localparam logic [1:0] c_grant_none = 2'b00;
    localparam logic [1:0] c_grant_m0   = 2'b01;
    localparam logic [1:0] c_grant_m1   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/rvga_cachebus_arbiter_wdog.sv
`default_nettype none
// ============================================================================
// Module : rvga_cachebus_arbiter_wdog
// Brief  : Saturating busy-cycle counter with a sticky stall flag.
// Rev    : 1.0  initial release
// ============================================================================
module rvga_cachebus_arbiter_wdog #(
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enter_i,
    input  logic own_i,
    input  logic resp_i,
    output logic err_o
);

    generate
        if (WDOG_CYCLES > 0) begin : g_wdog_on
            localparam int unsigned CW = $clog2(WDOG_CYCLES + 1);
            localparam logic [CW-1:0] c_limit = CW'(WDOG_CYCLES);

            logic [CW-1:0] cnt_q, cnt_d;
            logic          err_q, err_d;

            always_comb begin
                cnt_d = cnt_q;
                if (enter_i || resp_i) begin
                    cnt_d = '0;
                end else if (own_i && (cnt_q != c_limit)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                err_d = err_q | (cnt_d == c_limit);
            end

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    cnt_q <= '0;
                    err_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    err_q <= err_d;
                end
            end

            assign err_o = err_q;
        end else begin : g_wdog_off
            logic w_unused;
            assign w_unused = ^{clk_i, rst_ni, enter_i, own_i, resp_i};
            assign err_o    = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/rvga_cachebus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rvga_cachebus_arbiter
// Brief  : Two-master cachebus arbiter granting whole transactions to one memory port.
// Rev    : 1.0  initial release
// ============================================================================
module rvga_cachebus_arbiter
    import rvga_cachebus_arbiter_pkg::*;
#(
    parameter bit          FIXED_PRIO  = 1'b0,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  rvga_word   m0_addr_i,
    input  logic       m0_read_i,
    input  logic       m0_write_i,
    input  rvga_word   m0_wdata_i,
    output rvga_word   m0_rdata_o,
    output logic       m0_resp_o,
    input  rvga_word   m1_addr_i,
    input  logic       m1_read_i,
    input  logic       m1_write_i,
    input  rvga_word   m1_wdata_i,
    output rvga_word   m1_rdata_o,
    output logic       m1_resp_o,
    output rvga_word   mem_addr_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output rvga_word   mem_wdata_o,
    input  rvga_word   mem_rdata_i,
    input  logic       mem_resp_i,
    output logic [1:0] grant_o,
    output logic       wdog_err_o
);

    rvga_arb_state_e state_q;
    logic [1:0]      grant_q;
    logic            last_m1_q;

    logic w_m0_req, w_m1_req, w_enter, w_own;

    assign w_m0_req = m0_read_i | m0_write_i;
    assign w_m1_req = m1_read_i | m1_write_i;
    assign w_own    = (state_q != ARB_IDLE);
    assign w_enter  = (state_q == ARB_IDLE) && (w_m0_req || w_m1_req);

    // Returning to IDLE after every resp keeps a just-completed request from being re-issued.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ARB_IDLE;
            grant_q   <= c_grant_none;
            last_m1_q <= 1'b1;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (w_m0_req && (!w_m1_req || (!FIXED_PRIO && last_m1_q))) begin
                        state_q <= ARB_OWN_M0;
                        grant_q <= c_grant_m0;
                    end else if (w_m1_req) begin
                        state_q <= ARB_OWN_M1;
                        grant_q <= c_grant_m1;
                    end
                end
                ARB_OWN_M0: begin
                    if (mem_resp_i) begin
                        state_q   <= ARB_IDLE;
                        grant_q   <= c_grant_none;
                        last_m1_q <= 1'b0;
                    end
                end
                ARB_OWN_M1: begin
                    if (mem_resp_i) begin
                        state_q   <= ARB_IDLE;
                        grant_q   <= c_grant_none;
                        last_m1_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    grant_q <= c_grant_none;
                end
            endcase
        end
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_wdata_o = '0;
        m0_rdata_o  = '0;
        m0_resp_o   = 1'b0;
        m1_rdata_o  = '0;
        m1_resp_o   = 1'b0;
        case (state_q)
            ARB_OWN_M0: begin
                mem_addr_o  = m0_addr_i;
                mem_read_o  = m0_read_i;
                mem_write_o = m0_write_i;
                mem_wdata_o = m0_wdata_i;
                m0_rdata_o  = mem_rdata_i;
                m0_resp_o   = mem_resp_i;
            end
            ARB_OWN_M1: begin
                mem_addr_o  = m1_addr_i;
                mem_read_o  = m1_read_i;
                mem_write_o = m1_write_i;
                mem_wdata_o = m1_wdata_i;
                m1_rdata_o  = mem_rdata_i;
                m1_resp_o   = mem_resp_i;
            end
            default: ;
        endcase
    end

    assign grant_o = grant_q;

    rvga_cachebus_arbiter_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .enter_i (w_enter),
        .own_i   (w_own),
        .resp_i  (mem_resp_i),
        .err_o   (wdog_err_o)
    );

    // Master protocol violations: forwarded unchanged, flagged in simulation only.
    a_m0_rw_excl: assert property (@(posedge clk_i) disable iff (!rst_ni) !(m0_read_i && m0_write_i));
    a_m1_rw_excl: assert property (@(posedge clk_i) disable iff (!rst_ni) !(m1_read_i && m1_write_i));
    a_m0_hold:    assert property (@(posedge clk_i) disable iff (!rst_ni) (state_q == ARB_OWN_M0) |-> w_m0_req);
    a_m1_hold:    assert property (@(posedge clk_i) disable iff (!rst_ni) (state_q == ARB_OWN_M1) |-> w_m1_req);

endmodule
`default_nettype wire

// File: tb/tb_rvga_cachebus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_rvga_cachebus_arbiter
// Brief  : Self-checking bench with a transaction-level arbitration model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rvga_cachebus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Instance A: round-robin, short watchdog
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;
    logic        m0_read, m0_write, m1_read, m1_write, mem_resp;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
    logic        m0_resp, m1_resp, mem_read, mem_write, wdog;
    logic [1:0]  grant;

    // Instance B: fixed priority, watchdog disabled
    logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata, b_mem_rdata;
    logic        b_m0_read, b_m0_write, b_m1_read, b_m1_write, b_mem_resp;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata;
    logic        b_m0_resp, b_m1_resp, b_mem_read, b_mem_write, b_wdog;
    logic [1:0]  b_grant;

    rvga_cachebus_arbiter #(.FIXED_PRIO(1'b0), .WDOG_CYCLES(16)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_addr_i(m0_addr), .m0_read_i(m0_read), .m0_write_i(m0_write), .m0_wdata_i(m0_wdata),
        .m0_rdata_o(m0_rdata), .m0_resp_o(m0_resp),
        .m1_addr_i(m1_addr), .m1_read_i(m1_read), .m1_write_i(m1_write), .m1_wdata_i(m1_wdata),
        .m1_rdata_o(m1_rdata), .m1_resp_o(m1_resp),
        .mem_addr_o(mem_addr), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_resp_i(mem_resp),
        .grant_o(grant), .wdog_err_o(wdog)
    );

    rvga_cachebus_arbiter #(.FIXED_PRIO(1'b1), .WDOG_CYCLES(0)) u_dut_fixed (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_addr_i(b_m0_addr), .m0_read_i(b_m0_read), .m0_write_i(b_m0_write), .m0_wdata_i(b_m0_wdata),
        .m0_rdata_o(b_m0_rdata), .m0_resp_o(b_m0_resp),
        .m1_addr_i(b_m1_addr), .m1_read_i(b_m1_read), .m1_write_i(b_m1_write), .m1_wdata_i(b_m1_wdata),
        .m1_rdata_o(b_m1_rdata), .m1_resp_o(b_m1_resp),
        .mem_addr_o(b_mem_addr), .mem_read_o(b_mem_read), .mem_write_o(b_mem_write),
        .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata), .mem_resp_i(b_mem_resp),
        .grant_o(b_grant), .wdog_err_o(b_wdog)
    );

    int errors = 0;
    int checks = 0;
    int last_w = 1;   // model: master that completed most recently (reset value m1)
    int w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int idx, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (idx == 0) begin
            m0_read = rd; m0_write = wr; m0_addr = addr; m0_wdata = wd;
        end else begin
            m1_read = rd; m1_write = wr; m1_addr = addr; m1_wdata = wd;
        end
    endtask

    task automatic rand_req(input int idx);
        logic wr;
        wr = 1'($urandom_range(0, 1));
        set_m(idx, ~wr, wr, $urandom & 32'hFFFF_FFFC, $urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_m(0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0);
        mem_resp = 1'b0; mem_rdata = '0;
        tick(); tick();
        rst_n  = 1'b1;
        last_w = 1;
    endtask

    // One arbitrated transaction, starting from an IDLE cycle with requests presented.
    task automatic a_round(input int lat, input logic [31:0] rdv, output int win);
        logic r0, r1;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        if (r0 && r1) win = (last_w == 1) ? 0 : 1;
        else          win = r0 ? 0 : 1;
        chk("idle_grant", grant, 2'b00);
        chk("idle_mem_read", mem_read, 1'b0);
        chk("idle_mem_write", mem_write, 1'b0);
        tick();
        for (int c = 0; c <= lat; c++) begin
            if (c == lat) begin
                mem_resp = 1'b1; mem_rdata = rdv; #1;
            end
            chk("grant", grant, (win == 0) ? 2'b01 : 2'b10);
            chk("mem_addr", mem_addr, win ? m1_addr : m0_addr);
            chk("mem_read", mem_read, win ? m1_read : m0_read);
            chk("mem_write", mem_write, win ? m1_write : m0_write);
            chk("mem_wdata", mem_wdata, win ? m1_wdata : m0_wdata);
            chk("owner_resp", win ? m1_resp : m0_resp, (c == lat));
            chk("other_resp", win ? m0_resp : m1_resp, 1'b0);
            chk("other_rdata", win ? m0_rdata : m1_rdata, 32'h0);
            if (c == lat) chk("owner_rdata", win ? m1_rdata : m0_rdata, rdv);
            tick();
        end
        mem_resp = 1'b0;
        last_w   = win;
    endtask

    initial begin
        b_m0_addr = '0; b_m0_wdata = '0; b_m0_read = 0; b_m0_write = 0;
        b_m1_addr = '0; b_m1_wdata = '0; b_m1_read = 0; b_m1_write = 0;
        b_mem_rdata = '0; b_mem_resp = 0;
        do_reset();

        // Reset state
        chk("rst_grant", grant, 2'b00);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_m0_resp", m0_resp, 1'b0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_wdog", wdog, 1'b0);

        // m0 read, memory answers after 3 cycles
        set_m(0, 1, 0, 32'h0000_0100, 32'h0);
        a_round(3, 32'hDEAD_BEEF, w);
        set_m(0, 0, 0, 32'h0, 32'h0);
        chk("t1_resp_one_cycle", m0_resp, 1'b0);
        chk("t1_m1_resp", m1_resp, 1'b0);

        // m1 write, then one IDLE cycle with nothing driven
        set_m(1, 0, 1, 32'h0000_0200, 32'h1234_5678);
        a_round(2, 32'h0, w);
        set_m(1, 0, 0, 32'h0, 32'h0);
        chk("t4_idle_read", mem_read, 1'b0);
        chk("t4_idle_write", mem_write, 1'b0);
        chk("t4_idle_grant", grant, 2'b00);

        // Contention from reset: alternation m0,m1,m0,...
        do_reset();
        rand_req(0); rand_req(1);
        for (int i = 0; i < 8; i++) begin
            a_round($urandom_range(0, 3), $urandom, w);
            chk("t2_rr_owner", w, i % 2);
            rand_req(w);
        end
        set_m(0, 0, 0, 0, 0); set_m(1, 0, 0, 0, 0);
        tick();

        // Randomized traffic against the model
        for (int r = 0; r < 30; r++) begin
            if (!(m0_read | m0_write) && ($urandom_range(0, 1) == 1)) rand_req(0);
            if (!(m1_read | m1_write) && ($urandom_range(0, 1) == 1)) rand_req(1);
            if (!(m0_read | m0_write) && !(m1_read | m1_write)) begin
                mem_resp = 1'b1; mem_rdata = $urandom; #1;
                chk("stray_m0_resp", m0_resp, 1'b0);
                chk("stray_m1_resp", m1_resp, 1'b0);
                tick();
                mem_resp = 1'b0;
                chk("stray_grant", grant, 2'b00);
                rand_req(int'($urandom_range(0, 1)));
            end
            a_round($urandom_range(0, 4), $urandom, w);
            if ($urandom_range(0, 1) == 1) rand_req(w);
            else                           set_m(w, 0, 0, 0, 0);
        end

        // Fixed priority: m1 always wins, m0 starves
        do_reset();
        b_m0_read = 1; b_m0_addr = 32'h0000_0040;
        b_m1_read = 1; b_m1_addr = 32'h0000_0080;
        for (int i = 0; i < 4; i++) begin
            chk("t3_idle_grant", b_grant, 2'b00);
            tick();
            chk("t3_grant_m1", b_grant, 2'b10);
            chk("t3_mem_addr", b_mem_addr, b_m1_addr);
            tick();
            b_mem_resp = 1'b1; b_mem_rdata = $urandom; #1;
            chk("t3_m1_resp", b_m1_resp, 1'b1);
            chk("t3_m0_resp", b_m0_resp, 1'b0);
            tick();
            b_mem_resp = 1'b0;
            b_m1_addr  = b_m1_addr + 32'h4;
        end
        chk("t3_wdog_disabled", b_wdog, 1'b0);
        b_m0_read = 0; b_m1_read = 0;

        // Watchdog: memory stalls for 16 OWN cycles
        do_reset();
        set_m(0, 1, 0, 32'h0000_0300, 32'h0);
        tick();
        chk("t5_grant", grant, 2'b01);
        for (int i = 0; i < 15; i++) tick();
        chk("t5_wdog_before", wdog, 1'b0);
        tick();
        chk("t5_wdog_set", wdog, 1'b1);
        chk("t5_still_owned", grant, 2'b01);
        mem_resp = 1'b1; mem_rdata = 32'h5A5A_5A5A; #1;
        chk("t5_late_resp", m0_resp, 1'b1);
        tick();
        mem_resp = 1'b0;
        set_m(0, 0, 0, 0, 0);
        tick(); tick();
        chk("t5_wdog_sticky", wdog, 1'b1);
        chk("t5_idle_grant", grant, 2'b00);
        rst_n = 1'b0;
        tick();
        chk("t5_wdog_cleared", wdog, 1'b0);
        rst_n = 1'b1;
        last_w = 1;

        // Reset in the middle of an OWN_M0 transaction
        set_m(0, 1, 0, 32'h0000_0400, 32'h0);
        tick();
        chk("t6_grant_before", grant, 2'b01);
        chk("t6_read_before", mem_read, 1'b1);
        rst_n = 1'b0;
        set_m(0, 0, 0, 0, 0);
        tick();
        chk("t6_grant", grant, 2'b00);
        chk("t6_mem_read", mem_read, 1'b0);
        chk("t6_mem_write", mem_write, 1'b0);
        chk("t6_mem_addr", mem_addr, 32'h0);
        rst_n = 1'b1;
        mem_resp = 1'b1; mem_rdata = 32'hCAFE_F00D; #1;
        chk("t6_stray_m0_resp", m0_resp, 1'b0);
        chk("t6_stray_m1_resp", m1_resp, 1'b0);
        chk("t6_stray_m0_rdata", m0_rdata, 32'h0);
        tick();
        mem_resp = 1'b0;
        chk("t6_idle_after", grant, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
